// File: rtl/control_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states, opcode map
// and ALU select bit positions.
package control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_INCREMENT = 3'd3,
    ST_HALT      = 3'd4
  } state_e;

  localparam int OPCODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_LOAD = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_AND  = 4'h3;
  localparam logic [OPCODE_W-1:0] OP_IN   = 4'h4;
  localparam logic [OPCODE_W-1:0] OP_OUT  = 4'h5;
  localparam logic [OPCODE_W-1:0] OP_JMP  = 4'h6;
  localparam logic [OPCODE_W-1:0] OP_JZ   = 4'h7;
  localparam logic [OPCODE_W-1:0] OP_JNZ  = 4'h8;
  localparam logic [OPCODE_W-1:0] OP_JC   = 4'h9;
  localparam logic [OPCODE_W-1:0] OP_JNC  = 4'hA;
  localparam logic [OPCODE_W-1:0] OP_HLT  = 4'hF;

  localparam int ALU_S0 = 0;
  localparam int ALU_S1 = 1;
  localparam int ALU_S2 = 2;
  localparam int ALU_S3 = 3;
  localparam int ALU_S4 = 4;

  function automatic logic is_jump(input logic [OPCODE_W-1:0] op);
    return (op >= OP_JMP) && (op <= OP_JNC);
  endfunction

endpackage

// File: rtl/status_flags.sv
// Carry/zero status registers, loaded from the ALU flags on request and frozen
// while the clock enable is low.
module status_flags (
  input  logic clock_i,
  input  logic clear_i,
  input  logic ce_i,
  input  logic load_i,
  input  logic carry_i,
  input  logic zero_i,
  output logic carry_o,
  output logic zero_o
);

  logic carry_q, carry_d;
  logic zero_q, zero_d;

  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if (ce_i && load_i) begin
      carry_d = carry_i;
      zero_d  = zero_i;
    end
  end

  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign carry_o = carry_q;
  assign zero_o  = zero_q;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute/increment controller with memory-ready wait
// states, clock enable, conditional jumps on registered flags and HALT.
module control_unit #(
  parameter int IR_W = 8,
  parameter int OP_W = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            clock_enable,
  input  logic [IR_W-1:0] ir,
  input  logic            carry,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mux_a,
  output logic            mux_b,
  output logic            mux_c,
  output logic            en_da,
  output logic            en_pc,
  output logic            en_in,
  output logic            ram_we,
  output logic [4:0]      alu_sel,
  output logic            halted
);
  import control_pkg::*;

  if (OP_W != OPCODE_W) begin : g_bad_op_w
    $error("control_unit: opcode map needs OP_W == 4");
  end
  if (IR_W < OP_W) begin : g_bad_ir_w
    $error("control_unit: IR_W must be at least OP_W");
  end

  logic [OPCODE_W-1:0] op;
  assign op = ir[IR_W-1 -: OP_W];

  if (IR_W > OP_W) begin : g_operand
    logic unused_operand;
    assign unused_operand = ^ir[IR_W-OP_W-1:0];
  end

  state_e state_q, state_d;
  logic   carry_q, zero_q;
  logic   flag_load;
  logic   jump_taken;
  logic   op_alu_da;
  logic   dec_exe;

  assign op_alu_da = (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) ||
                     (op == OP_AND)  || (op == OP_IN);

  assign jump_taken = (op == OP_JMP) ||
                      ((op == OP_JZ)  &&  zero_q)  ||
                      ((op == OP_JNZ) && !zero_q)  ||
                      ((op == OP_JC)  &&  carry_q) ||
                      ((op == OP_JNC) && !carry_q);

  assign flag_load = (state_q == ST_EXECUTE) &&
                     ((op == OP_ADD) || (op == OP_SUB) || (op == OP_AND));

  status_flags u_flags (
    .clock_i (clock),
    .clear_i (clear),
    .ce_i    (clock_enable),
    .load_i  (flag_load),
    .carry_i (carry),
    .zero_i  (zero),
    .carry_o (carry_q),
    .zero_o  (zero_q)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_FETCH;
    end else if (clock_enable) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_in   = 1'b0;
    en_da   = 1'b0;
    en_pc   = 1'b0;
    ram_we  = 1'b0;
    mux_a   = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        en_in = 1'b1;
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (op_alu_da) begin
          en_da   = 1'b1;
          state_d = ST_INCREMENT;
        end else if (op == OP_OUT) begin
          ram_we = 1'b1;
          if (mem_ready) state_d = ST_INCREMENT;
        end else if (is_jump(op)) begin
          // A taken jump loads the target directly and skips INCREMENT.
          if (jump_taken) begin
            en_pc   = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_INCREMENT;
          end
        end else if (op == OP_HLT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_INCREMENT;
        end
      end
      ST_INCREMENT: begin
        en_pc   = 1'b1;
        mux_a   = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  assign mux_b = (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  assign mux_c = (op == OP_IN) || (op == OP_OUT);

  assign dec_exe = (state_q == ST_DECODE) || (state_q == ST_EXECUTE);

  always_comb begin
    alu_sel         = '0;
    alu_sel[ALU_S0] = dec_exe && ((op == OP_AND) || (op == OP_IN) ||
                                  (op == OP_LOAD) || is_jump(op));
    alu_sel[ALU_S1] = dec_exe && ((op == OP_LOAD) || (op == OP_IN) ||
                                  (op == OP_OUT) || is_jump(op));
    alu_sel[ALU_S2] = (state_q == ST_INCREMENT) || (dec_exe && (op == OP_SUB));
    alu_sel[ALU_S3] = dec_exe && (op == OP_SUB);
    alu_sel[ALU_S4] = (state_q == ST_INCREMENT);
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed, cycle-by-cycle vector bench for control_unit.
module tb_control_unit;

  logic       clock = 1'b0;
  logic       clear;
  logic       clock_enable;
  logic [7:0] ir;
  logic       carry, zero, mem_ready;
  logic       mux_a, mux_b, mux_c, en_da, en_pc, en_in, ram_we, halted;
  logic [4:0] alu_sel;

  int checks = 0;
  int errors = 0;

  control_unit #(.IR_W(8), .OP_W(4)) dut (
    .clock        (clock),
    .clear        (clear),
    .clock_enable (clock_enable),
    .ir           (ir),
    .carry        (carry),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mux_a        (mux_a),
    .mux_b        (mux_b),
    .mux_c        (mux_c),
    .en_da        (en_da),
    .en_pc        (en_pc),
    .en_in        (en_in),
    .ram_we       (ram_we),
    .alu_sel      (alu_sel),
    .halted       (halted)
  );

  always #5 clock = ~clock;

  // en = {en_in, en_da, en_pc, ram_we}; mux = {mux_a, mux_b, mux_c}
  typedef struct {
    logic [7:0] ir;
    logic       c, z, mr, ce;
    logic [3:0] en;
    logic [2:0] mux;
    logic       h;
    logic [4:0] alu;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [7:0] i, input logic c, input logic z,
                             input logic mr, input logic ce, input logic [3:0] en,
                             input logic [2:0] mux, input logic h, input logic [4:0] alu);
    vec_t r;
    r.ir = i; r.c = c; r.z = z; r.mr = mr; r.ce = ce;
    r.en = en; r.mux = mux; r.h = h; r.alu = alu;
    return r;
  endfunction

  function automatic logic [12:0] got();
    return {en_in, en_da, en_pc, ram_we, mux_a, mux_b, mux_c, halted, alu_sel};
  endfunction

  task automatic check_out(input string name, input logic [12:0] exp);
    logic [12:0] g;
    g = got();
    checks++;
    if (g !== exp) begin
      errors++;
      $display("FAIL %s: got en/da/pc/we=%b mux=%b halted=%b alu=%b, want en/da/pc/we=%b mux=%b halted=%b alu=%b",
               name, g[12:9], g[8:6], g[5], g[4:0], exp[12:9], exp[8:6], exp[5], exp[4:0]);
    end
  endtask

  task automatic apply(input vec_t t, input string name);
    ir = t.ir; carry = t.c; zero = t.z; mem_ready = t.mr; clock_enable = t.ce;
    #1;
    check_out(name, {t.en, t.mux, t.h, t.alu});
    @(posedge clock);
    #1;
  endtask

  initial begin
    clear = 1'b1; clock_enable = 1'b1; ir = 8'h00;
    carry = 1'b0; zero = 1'b0; mem_ready = 1'b0;

    // ADD: sets carry_q=1, zero_q=0
    tbl.push_back(v(8'h13,0,0,1,1,4'b1000,3'b010,0,5'b00000));
    tbl.push_back(v(8'h13,0,0,1,1,4'b0000,3'b010,0,5'b00000));
    tbl.push_back(v(8'h13,1,0,1,1,4'b0100,3'b010,0,5'b00000));
    tbl.push_back(v(8'h13,0,0,1,1,4'b0010,3'b110,0,5'b10100));
    // JNC with carry_q=1: not taken
    tbl.push_back(v(8'hA0,0,0,1,1,4'b1000,3'b000,0,5'b00000));
    tbl.push_back(v(8'hA0,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'hA0,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'hA0,0,0,1,1,4'b0010,3'b100,0,5'b10100));
    // JC with carry_q=1 (live carry low): taken, 3 cycles
    tbl.push_back(v(8'h90,0,0,1,1,4'b1000,3'b000,0,5'b00000));
    tbl.push_back(v(8'h90,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'h90,0,0,1,1,4'b0010,3'b000,0,5'b00011));
    // SUB with zero=1: carry_q=0, zero_q=1
    tbl.push_back(v(8'h25,0,0,1,1,4'b1000,3'b010,0,5'b00000));
    tbl.push_back(v(8'h25,0,0,1,1,4'b0000,3'b010,0,5'b01100));
    tbl.push_back(v(8'h25,0,1,1,1,4'b0100,3'b010,0,5'b01100));
    tbl.push_back(v(8'h25,0,0,1,1,4'b0010,3'b110,0,5'b10100));
    // JZ: taken on registered zero
    tbl.push_back(v(8'h7A,0,0,1,1,4'b1000,3'b000,0,5'b00000));
    tbl.push_back(v(8'h7A,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'h7A,0,0,1,1,4'b0010,3'b000,0,5'b00011));
    // JNZ with zero_q=1: not taken
    tbl.push_back(v(8'h80,0,0,1,1,4'b1000,3'b000,0,5'b00000));
    tbl.push_back(v(8'h80,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'h80,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'h80,0,0,1,1,4'b0010,3'b100,0,5'b10100));
    // LOAD with 3 fetch wait states; LOAD must not touch flags
    tbl.push_back(v(8'h0F,0,0,0,1,4'b1000,3'b010,0,5'b00000));
    tbl.push_back(v(8'h0F,0,0,0,1,4'b1000,3'b010,0,5'b00000));
    tbl.push_back(v(8'h0F,0,0,0,1,4'b1000,3'b010,0,5'b00000));
    tbl.push_back(v(8'h0F,0,0,1,1,4'b1000,3'b010,0,5'b00000));
    tbl.push_back(v(8'h0F,0,0,0,1,4'b0000,3'b010,0,5'b00011));
    tbl.push_back(v(8'h0F,1,1,0,1,4'b0100,3'b010,0,5'b00011));
    tbl.push_back(v(8'h0F,0,0,1,1,4'b0010,3'b110,0,5'b10100));
    // OUT with 2 store wait states
    tbl.push_back(v(8'h55,0,0,1,1,4'b1000,3'b001,0,5'b00000));
    tbl.push_back(v(8'h55,0,0,0,1,4'b0000,3'b001,0,5'b00010));
    tbl.push_back(v(8'h55,0,0,0,1,4'b0001,3'b001,0,5'b00010));
    tbl.push_back(v(8'h55,0,0,0,1,4'b0001,3'b001,0,5'b00010));
    tbl.push_back(v(8'h55,0,0,1,1,4'b0001,3'b001,0,5'b00010));
    tbl.push_back(v(8'h55,0,0,1,1,4'b0010,3'b101,0,5'b10100));
    // JC with carry_q=0 (LOAD left it alone): not taken
    tbl.push_back(v(8'h91,0,0,1,1,4'b1000,3'b000,0,5'b00000));
    tbl.push_back(v(8'h91,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'h91,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'h91,0,0,1,1,4'b0010,3'b100,0,5'b10100));
    // ADD frozen 2 cycles in EXECUTE; final flags carry_q=0, zero_q=0
    tbl.push_back(v(8'h1C,0,0,1,1,4'b1000,3'b010,0,5'b00000));
    tbl.push_back(v(8'h1C,0,0,1,1,4'b0000,3'b010,0,5'b00000));
    tbl.push_back(v(8'h1C,1,1,1,0,4'b0100,3'b010,0,5'b00000));
    tbl.push_back(v(8'h1C,1,1,1,0,4'b0100,3'b010,0,5'b00000));
    tbl.push_back(v(8'h1C,0,0,1,1,4'b0100,3'b010,0,5'b00000));
    tbl.push_back(v(8'h1C,0,0,1,1,4'b0010,3'b110,0,5'b10100));
    // JZ with zero_q=0: not taken
    tbl.push_back(v(8'h70,0,0,1,1,4'b1000,3'b000,0,5'b00000));
    tbl.push_back(v(8'h70,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'h70,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'h70,0,0,1,1,4'b0010,3'b100,0,5'b10100));
    // JNZ taken, fetch frozen one cycle despite mem_ready
    tbl.push_back(v(8'h8F,0,0,1,0,4'b1000,3'b000,0,5'b00000));
    tbl.push_back(v(8'h8F,0,0,1,1,4'b1000,3'b000,0,5'b00000));
    tbl.push_back(v(8'h8F,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'h8F,0,0,1,1,4'b0010,3'b000,0,5'b00011));
    // NOP
    tbl.push_back(v(8'hB0,0,0,1,1,4'b1000,3'b000,0,5'b00000));
    tbl.push_back(v(8'hB0,0,0,1,1,4'b0000,3'b000,0,5'b00000));
    tbl.push_back(v(8'hB0,0,0,1,1,4'b0000,3'b000,0,5'b00000));
    tbl.push_back(v(8'hB0,0,0,1,1,4'b0010,3'b100,0,5'b10100));
    // AND (carry_q=1, zero_q=1), IN, JMP
    tbl.push_back(v(8'h3C,0,0,1,1,4'b1000,3'b010,0,5'b00000));
    tbl.push_back(v(8'h3C,0,0,1,1,4'b0000,3'b010,0,5'b00001));
    tbl.push_back(v(8'h3C,1,1,1,1,4'b0100,3'b010,0,5'b00001));
    tbl.push_back(v(8'h3C,0,0,1,1,4'b0010,3'b110,0,5'b10100));
    tbl.push_back(v(8'h4C,0,0,1,1,4'b1000,3'b001,0,5'b00000));
    tbl.push_back(v(8'h4C,0,0,1,1,4'b0000,3'b001,0,5'b00011));
    tbl.push_back(v(8'h4C,0,0,1,1,4'b0100,3'b001,0,5'b00011));
    tbl.push_back(v(8'h4C,0,0,1,1,4'b0010,3'b101,0,5'b10100));
    tbl.push_back(v(8'h60,0,0,1,1,4'b1000,3'b000,0,5'b00000));
    tbl.push_back(v(8'h60,0,0,1,1,4'b0000,3'b000,0,5'b00011));
    tbl.push_back(v(8'h60,0,0,1,1,4'b0010,3'b000,0,5'b00011));
    // HLT then stays halted
    tbl.push_back(v(8'hF3,0,0,1,1,4'b1000,3'b000,0,5'b00000));
    tbl.push_back(v(8'hF3,0,0,1,1,4'b0000,3'b000,0,5'b00000));
    tbl.push_back(v(8'hF3,0,0,1,1,4'b0000,3'b000,0,5'b00000));
    tbl.push_back(v(8'hF3,0,0,1,1,4'b0000,3'b000,1,5'b00000));
    tbl.push_back(v(8'hF3,1,1,1,1,4'b0000,3'b000,1,5'b00000));
    tbl.push_back(v(8'hF3,0,0,0,1,4'b0000,3'b000,1,5'b00000));

    #1;
    check_out("reset", {4'b1000, 3'b010, 1'b0, 5'b00000});
    #11;
    clear = 1'b0;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // clear exits HALT immediately
    clear = 1'b1;
    #1;
    check_out("clear_halt", {4'b1000, 3'b000, 1'b0, 5'b00000});
    #1;
    clear = 1'b0;

    // flags were cleared: JC not taken
    apply(v(8'h90,0,0,1,1,4'b1000,3'b000,0,5'b00000), "jc_after_clr_f");
    apply(v(8'h90,1,1,1,1,4'b0000,3'b000,0,5'b00011), "jc_after_clr_d");
    apply(v(8'h90,0,0,1,1,4'b0000,3'b000,0,5'b00011), "jc_after_clr_e");
    apply(v(8'h90,0,0,1,1,4'b0010,3'b100,0,5'b10100), "jc_after_clr_i");

    // clear during OUT wait aborts to FETCH at once
    apply(v(8'h50,0,0,1,1,4'b1000,3'b001,0,5'b00000), "out_abort_f");
    apply(v(8'h50,0,0,0,1,4'b0000,3'b001,0,5'b00010), "out_abort_d");
    apply(v(8'h50,0,0,0,1,4'b0001,3'b001,0,5'b00010), "out_abort_w1");
    apply(v(8'h50,0,0,0,1,4'b0001,3'b001,0,5'b00010), "out_abort_w2");
    #2;
    clear = 1'b1;
    #1;
    check_out("clear_mid_out", {4'b1000, 3'b001, 1'b0, 5'b00000});
    @(posedge clock);
    #1;
    check_out("clear_held", {4'b1000, 3'b001, 1'b0, 5'b00000});
    clear = 1'b0;
    apply(v(8'h50,0,0,1,1,4'b1000,3'b001,0,5'b00000), "resume_f");
    apply(v(8'h50,0,0,1,1,4'b0000,3'b001,0,5'b00010), "resume_d");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Parametrised successor to the 8-bit CPU instruction decoder: a multi-cycle control FSM that sequences fetch/decode/execute/increment, decodes the opcode field of a configurable-width instruction register, holds carry/zero status and resolves conditional jumps. Adds a memory-ready handshake (wait states on fetch and store), a global clock enable, and a HALT instruction. Sits between the IR/RAM/ALU datapath and the program counter, driving all one-hot datapath enables.

## Interface
- IR_W, 8, instruction register width; opcode is IR[IR_W-1 -: OP_W]; legal IR_W ≥ OP_W
- OP_W, 4, opcode field width; fixed opcode map below requires OP_W = 4, and elaboration fails otherwise

- clock  in  1  system clock, rising edge
- clear  in  1  asynchronous, active-high reset
- clock_enable  in  1  when low, state, flags and all internal registers hold
- ir  in  IR_W  current instruction (external IR register, loaded by en_in)
- carry, zero  in  1  ALU flags, valid during EXECUTE
- mem_ready  in  1  RAM access complete this cycle
- mux_a, mux_b, mux_c  out  1  datapath mux selects
- en_da, en_pc, en_in, ram_we  out  1  register/RAM write enables
- alu_sel  out  5  ALU function select {s4,s3,s2,s1,s0}
- halted  out  1  high while in HALT

## Operation
- Opcodes: 0 LOAD, 1 ADD, 2 SUB, 3 AND, 4 IN, 5 OUT, 6 JMP, 7 JZ, 8 JNZ, 9 JC, A JNC, B–E NOP, F HLT.
- States: FETCH, DECODE, EXECUTE, INCREMENT, HALT. Reset state FETCH.
- FETCH: en_in = 1; advance to DECODE on cycle with mem_ready = 1, else stay.
- DECODE: no enables; always to EXECUTE.
- EXECUTE:
  - LOAD/ADD/SUB/AND/IN: en_da = 1 → INCREMENT.
  - OUT: ram_we = 1 while waiting; stay until mem_ready = 1, then INCREMENT.
  - Jumps: taken = JMP | JZ&zero_q | JNZ&!zero_q | JC&carry_q | JNC&!carry_q. Taken: en_pc = 1, mux_a = 0 → FETCH (INCREMENT skipped). Not taken → INCREMENT.
  - NOP → INCREMENT. HLT → HALT.
- INCREMENT: en_pc = 1, mux_a = 1 → FETCH.
- HALT: all enables 0, halted = 1; exit only via clear.
- mux_b = LOAD|ADD|SUB|AND; mux_c = IN|OUT (decoded from ir, any state).
- alu_sel: s0 = AND|IN|LOAD|jump; s1 = LOAD|IN|OUT|jump; s2 = INCREMENT|SUB; s3 = SUB; s4 = INCREMENT (state-qualified opcode terms active in DECODE and EXECUTE).
- Flags: carry_q/zero_q load carry/zero on the EXECUTE cycle of ADD, SUB, AND; otherwise hold.

## Timing
- Reset (asynchronous, immediate): state = FETCH, carry_q = zero_q = 0; outputs: en_in = 1, all other enables 0, alu_sel = 0, halted = 0.
- Outputs combinational from state and ir; no extra latency.
- Minimum instruction: 4 cycles (3 for taken jump); each cycle with mem_ready = 0 in FETCH or OUT-EXECUTE adds one.
- Flags used by a jump are those registered before its EXECUTE; no same-cycle forwarding.
- clock_enable = 0 freezes state and flags; outputs remain the decode of the frozen state (no implicit gating).
- clear mid-wait or mid-instruction aborts to FETCH; no partial flag update.

## Structure
- Package control_pkg: state enum, opcode constants, alu_sel bit-index constants.
- Sub-module status_flags: carry/zero registers with load enable, clock_enable, async clear.
- FSM, opcode decode and output logic stay in control_unit.

## Test plan
- Reset then ADD (ir = 8'h1x), mem_ready = 1, carry = 1: en_in, –, en_da, en_pc/mux_a/alu_sel = 5'b10100 on cycles 1–4; carry_q = 1 afterwards.
- SUB with zero = 1, then JZ (8'h7x): en_pc with mux_a = 0 in JZ EXECUTE, next state FETCH; 3-cycle jump.
- JNC with carry_q = 1: no en_pc in EXECUTE, INCREMENT follows with en_pc = 1, mux_a = 1.
- FETCH with mem_ready low 3 cycles, then OUT with mem_ready low 2 cycles: state held, en_in/ram_we steady, totals 4+3+2 cycles.
- HLT (8'hFx): halted = 1 indefinitely, all enables 0; clear → FETCH, halted = 0.
- clock_enable low 2 cycles during EXECUTE of ADD: no state or flag change; clear asserted mid-OUT wait: immediate FETCH, ram_we = 0.
